// File: rtl/board_view_engine.sv
// board_view_engine: draws background, piece sprites and selection boxes into a VGA pixel buffer
module board_view_engine #(
  parameter int GRID = 8,
  parameter int SQ = 28,
  parameter int BEZEL = 8,
  parameter int SCR_W = 320,
  parameter int SCR_H = 240,
  parameter int COLOR_W = 1,
  parameter int PIECE_W = 4,
  parameter int NUM_BOX = 2,
  parameter int BOX_T = 2,
  localparam int GW = $clog2(GRID),
  localparam int SW = $clog2(SQ),
  localparam int AW = $clog2(SCR_W * SCR_H)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode_sq,
  input  logic [GW-1:0]              sq_x,
  input  logic [GW-1:0]              sq_y,
  input  logic                       blink_tick,
  input  logic [NUM_BOX*GW-1:0]      box_x,
  input  logic [NUM_BOX*GW-1:0]      box_y,
  input  logic [NUM_BOX-1:0]         box_en,
  input  logic [NUM_BOX-1:0]         box_blink,
  input  logic [NUM_BOX*COLOR_W-1:0] box_col,
  output logic [GW-1:0]              view_x,
  output logic [GW-1:0]              view_y,
  input  logic [PIECE_W-1:0]         piece_read,
  output logic [AW-1:0]              bg_addr,
  input  logic [COLOR_W-1:0]         bg_data,
  output logic [PIECE_W-1:0]         spr_piece,
  output logic [SW-1:0]              spr_row,
  output logic [SW-1:0]              spr_col,
  input  logic [COLOR_W:0]           spr_data,
  output logic [8:0]                 x,
  output logic [7:0]                 y,
  output logic [COLOR_W-1:0]         colour,
  output logic                       write_en,
  output logic                       busy,
  output logic                       done
);
  localparam int BW = NUM_BOX > 1 ? $clog2(NUM_BOX) : 1;
  if (GRID * SQ + BEZEL > SCR_W || GRID * SQ + BEZEL > SCR_H) begin : g_fit
    $error("board does not fit on the screen");
  end
  typedef enum logic [2:0] {IDLE, BG, PADDR, PLATCH, SPR, NEXT, BOX, DONE} state_t;
  state_t state, state_n;
  logic msq, phase, act, wr_d, spr_d, box_d;
  logic fw, u_end, last, hit, last_box, on_edge, issue;
  logic [GW-1:0] gc, gr, bx, by, bx_i, by_i;
  logic [BW-1:0] bi;
  logic [8:0] u, ox, px, wlim;
  logic [7:0] v, oy, py, hlim;
  logic [PIECE_W-1:0] piece;
  logic [COLOR_W-1:0] bcol, bcol_d, col_i;
  always_comb begin
    fw = state == BG && !msq;
    wlim = fw ? 9'(SCR_W - 1) : 9'(SQ - 1);
    hlim = fw ? 8'(SCR_H - 1) : 8'(SQ - 1);
    u_end = u == wlim;
    last = u_end && v == hlim;
    ox = 9'(state == BOX ? bx : gc) * 9'(SQ) + 9'(BEZEL);
    oy = 8'(state == BOX ? by : gr) * 8'(SQ) + 8'(BEZEL);
    px = fw ? u : ox + u;
    py = fw ? v : oy + v;
    bx_i = box_x[bi*GW +: GW];
    by_i = box_y[bi*GW +: GW];
    col_i = box_col[bi*COLOR_W +: COLOR_W];
    hit = box_en[bi] && (!box_blink[bi] || phase) && (!msq || (bx_i == gc && by_i == gr));
    last_box = bi == BW'(NUM_BOX - 1);
    on_edge = u < 9'(BOX_T) || u >= 9'(SQ - BOX_T) || v < 8'(BOX_T) || v >= 8'(SQ - BOX_T);
    issue = state == BG || state == SPR || (state == BOX && act && on_edge);
    state_n = state;
    case (state)
      IDLE:    state_n = start ? BG : IDLE;
      BG:      state_n = last ? PADDR : BG;
      PADDR:   state_n = PLATCH;
      PLATCH:  state_n = piece_read == '0 ? NEXT : SPR;
      SPR:     state_n = last ? NEXT : SPR;
      NEXT:    state_n = (msq || (gc == GW'(GRID - 1) && gr == GW'(GRID - 1))) ? BOX : PADDR;
      BOX:     state_n = (last_box && (act ? last : !hit)) ? DONE : BOX;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy = state != IDLE;
    done = state == DONE;
    view_x = gc;
    view_y = gr;
    bg_addr = state == BG ? AW'(py) * AW'(SCR_W) + AW'(px) : '0;
    spr_piece = piece;
    spr_row = v[SW-1:0];
    spr_col = u[SW-1:0];
    write_en = wr_d && (!spr_d || spr_data[COLOR_W]);
    colour = !write_en ? '0 : spr_d ? spr_data[COLOR_W-1:0] : box_d ? bcol_d : bg_data;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      {msq, phase, act, wr_d, spr_d, box_d} <= '0;
      {gc, gr, bx, by, bi} <= '0;
      {u, v, piece, bcol, bcol_d, x, y} <= '0;
    end else begin
      phase <= phase ^ blink_tick;
      wr_d <= issue;
      spr_d <= state == SPR;
      box_d <= state == BOX;
      bcol_d <= bcol;
      if (issue) begin
        x <= px;
        y <= py;
      end
      if (state == BG || state == SPR || (state == BOX && act)) begin
        u <= u_end ? '0 : u + 9'd1;
        if (u_end) v <= last ? '0 : v + 8'd1;
      end
      if (state == IDLE && start) begin
        msq <= mode_sq;
        gc <= mode_sq ? sq_x : '0;
        gr <= mode_sq ? sq_y : '0;
        u <= '0;
        v <= '0;
      end
      if (state == PLATCH) piece <= piece_read;
      if (state == NEXT) begin
        bi <= '0;
        act <= 1'b0;
        if (!msq) begin
          gc <= gc == GW'(GRID - 1) ? '0 : gc + 1'b1;
          if (gc == GW'(GRID - 1)) gr <= gr + 1'b1;
        end
      end
      if (state == BOX && !act) begin
        if (hit) begin
          act <= 1'b1;
          bx <= bx_i;
          by <= by_i;
          bcol <= col_i;
        end else bi <= bi + 1'b1;
      end
      if (state == BOX && act && last) begin
        act <= 1'b0;
        bi <= bi + 1'b1;
      end
    end
  end
endmodule
